// File: rtl/instr_fetch.sv
// instr_fetch: PC + synchronous instruction memory + prefetch FIFO with valid/ready output
module instr_fetch #(
  parameter int          MEM_DEPTH  = 64,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        instr_ready,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic        halted
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int MW = $clog2(MEM_DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
  state_t        state;
  logic [31:0]   inst_mem [MEM_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [31:0]   fifo_pc [FIFO_DEPTH];
  logic [31:0]   pc, rd_data, rd_pc;
  logic          inflight, pop, push, room, active, out_of_range, issue, go_halt;
  logic [AW-1:0] head, tail, nxt_head;
  logic [AW:0]   count, occ;
  assign instr_valid  = count != '0;
  assign halted       = state == HALT;
  assign pop          = instr_valid && instr_ready;
  assign push         = inflight && !jump_en;
  assign occ          = count - (AW+1)'(pop);
  assign room         = (occ + (AW+1)'(inflight)) < (AW+1)'(FIFO_DEPTH);
  assign out_of_range = pc[31:2] >= 30'(MEM_DEPTH);
  assign active       = fetch_en && state != HALT && !jump_en && room;
  assign issue        = active && !out_of_range;
  assign go_halt      = active && out_of_range;
  assign nxt_head     = head + AW'(pop);
  // Storage and memory read port carry no reset; validity is tracked by count/inflight.
  always_ff @(posedge clk) begin
    if (issue) begin
      rd_data <= inst_mem[pc[MW+1:2]];
      rd_pc   <= pc;
    end
    if (push) begin
      fifo_data[tail] <= rd_data;
      fifo_pc[tail]   <= rd_pc;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      inflight  <= 1'b0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      instr_out <= '0;
      pc_out    <= '0;
    end else begin
      inflight <= issue;
      pc       <= jump_en ? (jump_addr & ~32'h3) : issue ? pc + 32'd4 : pc;
      state    <= state == HALT ? (jump_en ? FETCH : HALT) : go_halt ? HALT : fetch_en ? FETCH : IDLE;
      if (jump_en) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        head  <= nxt_head;
        tail  <= tail + AW'(push);
        count <= occ + (AW+1)'(push);
        // Output registers track the next head; when the FIFO drains they keep the last entry.
        if (occ != '0) begin
          instr_out <= fifo_data[nxt_head];
          pc_out    <= fifo_pc[nxt_head];
        end else if (push) begin
          instr_out <= rd_data;
          pc_out    <= rd_pc;
        end
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and randomized checks of instr_fetch against an in-order delivery model
module tb_instr_fetch;
  logic        clk = 0, rst = 1, fetch_en = 0, instr_ready = 0, jump_en = 0;
  logic [31:0] jump_addr = 0, instr_out, pc_out;
  logic        instr_valid, halted;
  logic [31:0] mem_model [64];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .instr_ready(instr_ready),
    .jump_en(jump_en), .jump_addr(jump_addr), .instr_out(instr_out),
    .instr_valid(instr_valid), .pc_out(pc_out), .halted(halted)
  );

  task automatic do_reset;
    rst = 1; fetch_en = 0; instr_ready = 0; jump_en = 0; jump_addr = 0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset;
    rst = 1; fetch_en = 1; instr_ready = 1; jump_en = 0;
    repeat (2) @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instr_out); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", pc_out); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
  endtask

  task automatic test_stream;
    do_reset;
    fetch_en = 1; instr_ready = 1;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_latency: valid %b after 1 cycle, expected 0", instr_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || pc_out !== 32'(i*4) || instr_out !== mem_model[i]) begin
        errors++; $display("FAIL stream_%0d: valid %b pc %h instr %h, expected valid 1 pc %h instr %h", i, instr_valid, pc_out, instr_out, 32'(i*4), mem_model[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    fetch_en = 1; instr_ready = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 1) begin
        checks++;
        if (instr_valid !== 1'b1 || pc_out !== 32'h0 || instr_out !== mem_model[0]) begin
          errors++; $display("FAIL stall_head_%0d: valid %b pc %h instr %h, expected valid 1 pc 0 instr %h", i, instr_valid, pc_out, instr_out, mem_model[0]);
        end
      end
    end
    instr_ready = 1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || pc_out !== 32'(i*4) || instr_out !== mem_model[i]) begin
        errors++; $display("FAIL release_%0d: valid %b pc %h, expected valid 1 pc %h", i, instr_valid, pc_out, 32'(i*4));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect;
    int n;
    do_reset;
    fetch_en = 1; instr_ready = 1;
    repeat (4) @(negedge clk);
    instr_ready = 0;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h8) begin errors++; $display("FAIL redirect_setup: valid %b pc %h, expected valid 1 pc 8", instr_valid, pc_out); end
    jump_en = 1; jump_addr = 32'h22; instr_ready = 1;
    @(negedge clk);
    jump_en = 0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redirect_flush: valid %b expected 0", instr_valid); end
    n = 0;
    while (!instr_valid && n < 10) begin @(negedge clk); n++; end
    checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h20 || instr_out !== mem_model[8]) begin errors++; $display("FAIL redirect_target: valid %b pc %h, expected valid 1 pc 20", instr_valid, pc_out); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h24) begin errors++; $display("FAIL redirect_next: valid %b pc %h, expected valid 1 pc 24", instr_valid, pc_out); end
  endtask

  task automatic test_halt;
    logic [31:0] exp;
    int n;
    do_reset;
    jump_en = 1; jump_addr = 32'hF2;
    @(negedge clk);
    jump_en = 0; fetch_en = 1; instr_ready = 1;
    exp = 32'hF0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        checks++;
        if (pc_out !== exp || instr_out !== mem_model[exp[7:2]]) begin errors++; $display("FAIL halt_stream: pc %h expected %h", pc_out, exp); end
        exp += 4;
      end
    end
    checks++; if (exp !== 32'h100) begin errors++; $display("FAIL halt_count: next pc %h expected 100", exp); end
    checks++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL halt_state: halted %b valid %b, expected 1 0", halted, instr_valid); end
    fetch_en = 0;
    @(negedge clk);
    fetch_en = 1;
    repeat (3) @(negedge clk);
    checks++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL halt_sticky: halted %b valid %b, expected 1 0", halted, instr_valid); end
    jump_en = 1; jump_addr = 32'h0;
    @(negedge clk);
    jump_en = 0;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear: halted %b expected 0", halted); end
    n = 0;
    while (!instr_valid && n < 10) begin @(negedge clk); n++; end
    checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h0 || instr_out !== mem_model[0]) begin errors++; $display("FAIL halt_resume: valid %b pc %h, expected valid 1 pc 0", instr_valid, pc_out); end
  endtask

  task automatic test_async_reset;
    int n;
    do_reset;
    jump_en = 1; jump_addr = 32'h40;
    @(negedge clk);
    jump_en = 0; fetch_en = 1; instr_ready = 0;
    repeat (5) @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h40) begin errors++; $display("FAIL areset_setup: valid %b pc %h, expected valid 1 pc 40", instr_valid, pc_out); end
    #2 rst = 1;
    #1;
    checks++; if (instr_valid !== 1'b0 || instr_out !== 32'h0 || pc_out !== 32'h0 || halted !== 1'b0) begin
      errors++; $display("FAIL areset_clear: valid %b instr %h pc %h halted %b, expected all 0", instr_valid, instr_out, pc_out, halted);
    end
    @(negedge clk);
    rst = 0; instr_ready = 1;
    n = 0;
    while (!instr_valid && n < 10) begin @(negedge clk); n++; end
    checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h0 || instr_out !== mem_model[0]) begin errors++; $display("FAIL areset_restart: valid %b pc %h, expected valid 1 pc 0", instr_valid, pc_out); end
  endtask

  task automatic test_enable_toggle;
    int got, n;
    do_reset;
    instr_ready = 1; fetch_en = 1;
    @(negedge clk);
    fetch_en = 0;
    got = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        checks++;
        if (pc_out !== 32'h0) begin errors++; $display("FAIL toggle_inflight: pc %h expected 0", pc_out); end
        got++;
      end
    end
    checks++; if (got !== 1) begin errors++; $display("FAIL toggle_count: delivered %0d expected 1", got); end
    fetch_en = 1;
    n = 0;
    while (!instr_valid && n < 10) begin @(negedge clk); n++; end
    checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h4) begin errors++; $display("FAIL toggle_resume: valid %b pc %h, expected valid 1 pc 4", instr_valid, pc_out); end
  endtask

  // Model: instructions are delivered strictly in order from the last redirect target, each
  // matching memory; any skip, duplicate or stale post-flush entry breaks the expected PC.
  task automatic test_random;
    logic [31:0] exp_pc;
    do_reset;
    exp_pc = 32'h0;
    @(negedge clk);
    for (int i = 0; i < 800; i++) begin
      if (instr_valid) begin
        checks++;
        if (pc_out !== exp_pc || instr_out !== mem_model[pc_out[7:2]]) begin
          errors++; $display("FAIL random_%0d: pc %h instr %h, expected pc %h instr %h", i, pc_out, instr_out, exp_pc, mem_model[exp_pc[7:2]]);
        end
      end
      instr_ready = $urandom_range(0, 3) != 0;
      fetch_en    = $urandom_range(0, 7) != 0;
      jump_en     = $urandom_range(0, 24) == 0;
      jump_addr   = $urandom_range(0, 300);
      if (instr_valid && instr_ready) exp_pc += 4;
      if (jump_en) exp_pc = jump_addr & ~32'h3;
      @(negedge clk);
    end
    jump_en = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_model[i] = $urandom;
      dut.inst_mem[i] = mem_model[i];
    end
    test_reset;
    test_stream;
    test_backpressure;
    test_redirect;
    test_halt;
    test_async_reset;
    test_enable_toggle;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
